// File: rtl/ub_seq_pkg.sv
// Shared types and constants for the unified-buffer sequencer.
package ub_seq_pkg;

  localparam int UB_DEPTH       = 64;
  localparam int ADDR_W         = 13;
  localparam int CNT_W          = 4;
  localparam int TIMEOUT_CYC    = 255;
  localparam int WORDS_PER_TILE = 4;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_WAIT,
    STORE_ISSUE,
    DONE
  } ub_seq_state_e;

  // Word address of tile idx within a command starting at base.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + ADDR_W'(idx) * ADDR_W'(WORDS_PER_TILE);
  endfunction

endpackage

// File: rtl/ub_seq_if.sv
// Command, accumulator-flag and UB control bundle between decoder and sequencer.
interface ub_seq_if;
  import ub_seq_pkg::*;

  // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready is high only while the sequencer is idle and does not depend on cmd_valid.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [CNT_W-1:0]  cmd_tiles;
  logic              acc_full1;
  logic              acc_full2;
  logic [ADDR_W-1:0] ub_addr;
  logic              ub_load_input;
  logic              ub_store;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_tiles, acc_full1, acc_full2,
    input  cmd_ready, ub_addr, ub_load_input, ub_store, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_tiles, acc_full1, acc_full2,
    output cmd_ready, ub_addr, ub_load_input, ub_store, busy, done, err
  );

endinterface

// File: rtl/ub_seq_edge_det.sv
// Rising-edge detector on (acc_full1 && acc_full2); prime forces the history low.
module ub_seq_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic prime,
  input  logic acc_full1,
  input  logic acc_full2,
  output logic rise
);

  logic and_now;
  logic and_q;
  logic and_d;

  always_comb begin
    and_now = acc_full1 && acc_full2;
    and_d   = prime ? 1'b0 : and_now;
    rise    = and_now && !and_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      and_q <= 1'b0;
    end else begin
      and_q <= and_d;
    end
  end

endmodule

// File: rtl/ub_sequencer.sv
// Expands LOAD/STORE tile commands into registered unified-buffer strobes.
// Optional build macro UB_SEQ_TIMEOUT_EN aborts a STORE stuck waiting for the accumulators.
module ub_sequencer
  import ub_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  ub_seq_if.slave       bus,
  output ub_seq_state_e dbg_state
);

  ub_seq_state_e     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  tiles_q, tiles_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W+2:0] span;
  logic              reject;
  logic              rise;
  logic              last_tile;
`ifdef UB_SEQ_TIMEOUT_EN
  logic [7:0]        wait_q, wait_d;
`endif

  // History stays cleared while idle, so a flag pair already high at command start is an edge;
  // between tiles it keeps tracking, so flags held high do not retrigger.
  ub_seq_edge_det u_edge (
    .clk       (clk),
    .reset     (reset),
    .prime     (state_q == IDLE),
    .acc_full1 (bus.acc_full1),
    .acc_full2 (bus.acc_full2),
    .rise      (rise)
  );

  always_comb begin
    span   = {3'b000, bus.cmd_addr}
           + (ADDR_W+3)'(bus.cmd_tiles) * (ADDR_W+3)'(WORDS_PER_TILE);
    reject = (bus.cmd_addr[1:0] != 2'b00) || (span > (ADDR_W+3)'(UB_DEPTH));
    last_tile = (idx_q == tiles_q - CNT_W'(1));
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    tiles_d = tiles_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    load_d  = 1'b0;
    store_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef UB_SEQ_TIMEOUT_EN
    wait_d  = 8'd0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (reject) begin
            err_d = 1'b1;
          end else if (bus.cmd_tiles == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            base_d  = bus.cmd_addr;
            tiles_d = bus.cmd_tiles;
            idx_d   = '0;
            if (bus.cmd_op == OP_LOAD) begin
              state_d = LOAD;
              load_d  = 1'b1;
              addr_d  = bus.cmd_addr;
            end else begin
              state_d = STORE_WAIT;
            end
          end
        end
      end
      LOAD: begin
        if (last_tile) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d  = idx_q + CNT_W'(1);
          load_d = 1'b1;
          addr_d = tile_addr(base_q, idx_q + CNT_W'(1));
        end
      end
      STORE_WAIT: begin
        if (rise) begin
          state_d = STORE_ISSUE;
          store_d = 1'b1;
          addr_d  = tile_addr(base_q, idx_q);
        end else begin
`ifdef UB_SEQ_TIMEOUT_EN
          if (wait_q == 8'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
`endif
        end
      end
      STORE_ISSUE: begin
        if (last_tile) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = STORE_WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      tiles_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UB_SEQ_TIMEOUT_EN
      wait_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      tiles_q <= tiles_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
      store_q <= store_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef UB_SEQ_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  assign bus.cmd_ready     = (state_q == IDLE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.ub_addr       = addr_q;
  assign bus.ub_load_input = load_q;
  assign bus.ub_store      = store_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign dbg_state         = state_q;

endmodule
